vend_dispense_ctrl: RTL and testbench

- Sequences the physical dispense stage of the vending machine once the credit FSM has accepted a purchase.
- Runs the product motor for a fixed time and waits for the customer's collected confirmation.
- Pays out the owed change as discrete coin-hopper pulses, one per credit unit.
- Sits between the credit/selection FSM (requester) and the motor/hopper outputs. Reports busy/done back so the FSM can return to idle.

---
 rtl/vend_dispense_ctrl_if.sv | 27 ++
 rtl/vend_dispense_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_vend_dispense_ctrl.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vend_dispense_ctrl_if.sv
// Request/response bundle between the credit FSM, the customer sensor and the dispense stage.
// The master side drives the request, change amount and collect confirmation.
interface vend_dispense_ctrl_if #(
    parameter int unsigned CHANGE_W = 4
) ();
    logic                vend_req;
    logic [CHANGE_W-1:0] change_in;
    logic                collected;
    logic                vend_ack;
    logic                motor;
    logic                hopper_pulse;
    logic [CHANGE_W-1:0] change_left;
    logic                busy;
    logic                done;
    logic                timeout;
    logic [2:0]          state;

    modport master (
        output vend_req, change_in, collected,
        input  vend_ack, motor, hopper_pulse, change_left, busy, done, timeout, state
    );

    modport slave (
        input  vend_req, change_in, collected,
        output vend_ack, motor, hopper_pulse, change_left, busy, done, timeout, state
    );
endinterface

// File: rtl/vend_dispense_ctrl.sv
// Dispense sequencer: motor run, collect wait, then one hopper pulse per owed coin.
// Define VEND_COLLECT_TIMEOUT_EN to give up waiting for collected after COLLECT_TIMEOUT cycles.
module vend_dispense_ctrl #(
    parameter int unsigned CHANGE_W        = 4,
    parameter int unsigned MOTOR_CYCLES    = 8,
    parameter int unsigned HOPPER_ON       = 2,
    parameter int unsigned HOPPER_OFF      = 2,
    parameter int unsigned COLLECT_TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    vend_dispense_ctrl_if.slave   bus
);

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StMotor   = 3'd1,
        StWaitCol = 3'd2,
        StPayOn   = 3'd3,
        StPayOff  = 3'd4,
        StDone    = 3'd5
    } state_e;

    // One phase counter shared by motor, hopper-on and hopper-off phases.
    localparam int unsigned MaxMh  = (MOTOR_CYCLES > HOPPER_ON) ? MOTOR_CYCLES : HOPPER_ON;
    localparam int unsigned CntMax = (MaxMh > HOPPER_OFF) ? MaxMh : HOPPER_OFF;
    localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;

    localparam logic [CntW-1:0] MotorLast = CntW'(MOTOR_CYCLES - 1);
    localparam logic [CntW-1:0] OnLast    = CntW'(HOPPER_ON - 1);
    localparam logic [CntW-1:0] OffLast   = CntW'(HOPPER_OFF - 1);

    if (MOTOR_CYCLES < 1 || HOPPER_ON < 1 || HOPPER_OFF < 1 || COLLECT_TIMEOUT < 1)
    begin : g_param_check
        $error("vend_dispense_ctrl: cycle-count parameters must be at least 1");
    end

    state_e              state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [CHANGE_W-1:0] change_left_q, change_left_d;
    logic                vend_ack_q, vend_ack_d;
    logic                motor_q, motor_d;
    logic                hopper_q, hopper_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                collect_go;

`ifdef VEND_COLLECT_TIMEOUT_EN
    localparam int unsigned     TmoW    = (COLLECT_TIMEOUT > 1) ? $clog2(COLLECT_TIMEOUT) : 1;
    localparam logic [TmoW-1:0] TmoLast = TmoW'(COLLECT_TIMEOUT - 1);

    logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic            timeout_q, timeout_d;
`endif

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        change_left_d = change_left_q;
        vend_ack_d    = 1'b0;
        collect_go    = 1'b0;
`ifdef VEND_COLLECT_TIMEOUT_EN
        timeout_d     = timeout_q;
        tmo_cnt_d     = '0;
`endif
        unique case (state_q)
            StIdle: begin
                if (bus.vend_req) begin
                    change_left_d = bus.change_in;
                    vend_ack_d    = 1'b1;
                    cnt_d         = '0;
                    state_d       = StMotor;
`ifdef VEND_COLLECT_TIMEOUT_EN
                    timeout_d     = 1'b0;
`endif
                end
            end
            StMotor: begin
                if (cnt_q == MotorLast) begin
                    cnt_d   = '0;
                    state_d = StWaitCol;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StWaitCol: begin
                collect_go = bus.collected;
`ifdef VEND_COLLECT_TIMEOUT_EN
                // A collect arriving on the expiry cycle wins over the timeout.
                if (!bus.collected) begin
                    if (tmo_cnt_q == TmoLast) begin
                        collect_go = 1'b1;
                        timeout_d  = 1'b1;
                    end else begin
                        tmo_cnt_d = tmo_cnt_q + TmoW'(1);
                    end
                end
`endif
                if (collect_go) begin
                    cnt_d   = '0;
                    state_d = (change_left_q != '0) ? StPayOn : StDone;
                end
            end
            StPayOn: begin
                if (cnt_q == OnLast) begin
                    cnt_d   = '0;
                    state_d = StPayOff;
                    if (change_left_q != '0) begin
                        change_left_d = change_left_q - CHANGE_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StPayOff: begin
                if (cnt_q == OffLast) begin
                    cnt_d   = '0;
                    state_d = (change_left_q != '0) ? StPayOn : StDone;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Outputs are decoded from the next state so they register alongside it.
        motor_d  = (state_d == StMotor);
        hopper_d = (state_d == StPayOn);
        busy_d   = (state_d != StIdle);
        done_d   = (state_d == StDone);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            change_left_q <= '0;
            vend_ack_q    <= 1'b0;
            motor_q       <= 1'b0;
            hopper_q      <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            change_left_q <= change_left_d;
            vend_ack_q    <= vend_ack_d;
            motor_q       <= motor_d;
            hopper_q      <= hopper_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

`ifdef VEND_COLLECT_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmo_cnt_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.timeout = timeout_q;
`else
    assign bus.timeout = 1'b0;
`endif

    assign bus.vend_ack     = vend_ack_q;
    assign bus.motor        = motor_q;
    assign bus.hopper_pulse = hopper_q;
    assign bus.change_left  = change_left_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.state        = state_q;

endmodule

// File: tb/tb_vend_dispense_ctrl.sv
// Bench for vend_dispense_ctrl: per-cycle vector table plus directed multi-cycle sequences.
// Timeout checks switch with VEND_COLLECT_TIMEOUT_EN.
module tb_vend_dispense_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;

    vend_dispense_ctrl_if #(.CHANGE_W(4)) bus ();

    vend_dispense_ctrl #(
        .CHANGE_W       (4),
        .MOTOR_CYCLES   (8),
        .HOPPER_ON      (2),
        .HOPPER_OFF     (2),
        .COLLECT_TIMEOUT(64)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #10 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    // {inputs, expected {ack, motor, hopper, change_left, busy, done, state}}
    typedef struct packed {
        logic        req;
        logic [3:0]  chg;
        logic        col;
        logic [11:0] exp;
    } vec_t;

    typedef struct {
        int acks;
        int motor_at_ack;
        int motor_cyc;
        int pulses;
        int on_cyc;
        int wait_cyc;
        int dones;
        int tmo_at_ack;
        int tmo_at_done;
        int cl_rise1;
        int cl_rise2;
        int off_gap;
        int done_gap;
        int final_cl;
        int busy_after;
        int finished;
    } run_t;

    vec_t tbl[17];

    function automatic vec_t mk(input logic req, input int chg, input logic col, input logic ack,
                                input logic mot, input logic hop, input int cl, input logic busy,
                                input logic done, input int st);
        vec_t v;
        v.req = req;
        v.chg = 4'(chg);
        v.col = col;
        v.exp = {ack, mot, hop, 4'(cl), busy, done, 3'(st)};
        return v;
    endfunction

    function automatic logic [11:0] outvec();
        return {bus.vend_ack, bus.motor, bus.hopper_pulse, bus.change_left, bus.busy, bus.done,
                bus.state};
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s act=%0d exp=%0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete vend; col_delay < 0 means collected is never driven.
    task automatic vend_run(input int chg, input int col_delay, output run_t r);
        int   fall_m = -1;
        int   fall1 = -1;
        int   rise2 = -1;
        int   last_fall = -1;
        int   done_cyc = -1;
        logic prev_m = 1'b0;
        logic prev_h = 1'b0;
        r = '{default: 0};
        r.cl_rise1 = -1;
        r.cl_rise2 = -1;
        bus.vend_req  = 1'b1;
        bus.change_in = 4'(chg);
        bus.collected = 1'b0;
        for (int i = 0; i < 400 && r.finished == 0; i++) begin
            step();
            bus.vend_req  = 1'b0;
            bus.collected = 1'b0;
            if (bus.vend_ack) begin
                r.acks++;
                r.motor_at_ack = int'(bus.motor);
                r.tmo_at_ack   = int'(bus.timeout);
            end
            if (bus.motor) r.motor_cyc++;
            if (bus.state == 3'd2) r.wait_cyc++;
            if (bus.hopper_pulse) begin
                r.on_cyc++;
                if (!prev_h) begin
                    r.pulses++;
                    if (r.pulses == 1) r.cl_rise1 = int'(bus.change_left);
                    if (r.pulses == 2) begin
                        r.cl_rise2 = int'(bus.change_left);
                        rise2 = i;
                    end
                end
            end
            if (prev_h && !bus.hopper_pulse) begin
                last_fall = i;
                if (fall1 < 0) fall1 = i;
            end
            if (prev_m && !bus.motor) fall_m = i;
            if (bus.done) begin
                r.dones++;
                r.tmo_at_done = int'(bus.timeout);
                done_cyc = i;
                r.finished = 1;
            end
            if (col_delay >= 0 && fall_m >= 0 && i == fall_m + col_delay) bus.collected = 1'b1;
            prev_m = bus.motor;
            prev_h = bus.hopper_pulse;
        end
        r.off_gap  = (rise2 >= 0) ? rise2 - fall1 : -1;
        r.done_gap = (last_fall >= 0) ? done_cyc - last_fall : -1;
        step();
        r.final_cl   = int'(bus.change_left);
        r.busy_after = int'(bus.busy);
        r.dones      = r.dones + int'(bus.done);
    endtask

    run_t r;
    int   rises;
    logic prev_h;

    initial begin
        tbl[0]  = mk(1, 1, 0, 1, 1, 0, 1, 1, 0, 1);
        tbl[1]  = mk(0, 0, 1, 0, 1, 0, 1, 1, 0, 1);
        tbl[2]  = mk(1, 7, 1, 0, 1, 0, 1, 1, 0, 1);
        tbl[3]  = mk(1, 7, 1, 0, 1, 0, 1, 1, 0, 1);
        tbl[4]  = mk(0, 0, 1, 0, 1, 0, 1, 1, 0, 1);
        tbl[5]  = mk(0, 0, 1, 0, 1, 0, 1, 1, 0, 1);
        tbl[6]  = mk(0, 0, 1, 0, 1, 0, 1, 1, 0, 1);
        tbl[7]  = mk(0, 0, 1, 0, 1, 0, 1, 1, 0, 1);
        tbl[8]  = mk(0, 0, 1, 0, 0, 0, 1, 1, 0, 2);
        tbl[9]  = mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 2);
        tbl[10] = mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 2);
        tbl[11] = mk(0, 0, 1, 0, 0, 1, 1, 1, 0, 3);
        tbl[12] = mk(0, 0, 0, 0, 0, 1, 1, 1, 0, 3);
        tbl[13] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 4);
        tbl[14] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 4);
        tbl[15] = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 5);
        tbl[16] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        bus.vend_req  = 1'b0;
        bus.change_in = '0;
        bus.collected = 1'b0;
        step();
        step();
        check("reset_outputs", int'(outvec()), 0);
        check("reset_timeout", int'(bus.timeout), 0);
        @(negedge clk);
        rst = 1'b1;
        step();
        check("idle_after_reset", int'(outvec()), 0);

        // Vend with 1 coin; busy request mid-motor and early collected are both ignored.
        for (int i = 0; i < 17; i++) begin
            bus.vend_req  = tbl[i].req;
            bus.change_in = tbl[i].chg;
            bus.collected = tbl[i].col;
            step();
            checks++;
            if (outvec() !== tbl[i].exp) begin
                failures++;
                $display("FAIL vec%0d act=%03h exp=%03h", i, outvec(), tbl[i].exp);
            end
        end
        bus.collected = 1'b0;

        vend_run(0, 3, r);
        check("exact_finished", r.finished, 1);
        check("exact_acks", r.acks, 1);
        check("exact_motor_at_ack", r.motor_at_ack, 1);
        check("exact_motor_cycles", r.motor_cyc, 8);
        check("exact_pulses", r.pulses, 0);
        check("exact_dones", r.dones, 1);
        check("exact_busy_after", r.busy_after, 0);
        check("exact_timeout", r.tmo_at_done, 0);

        vend_run(2, 0, r);
        check("chg2_finished", r.finished, 1);
        check("chg2_pulses", r.pulses, 2);
        check("chg2_on_cycles", r.on_cyc, 4);
        check("chg2_cl_rise1", r.cl_rise1, 2);
        check("chg2_cl_rise2", r.cl_rise2, 1);
        check("chg2_off_gap", r.off_gap, 2);
        check("chg2_done_gap", r.done_gap, 2);
        check("chg2_final_cl", r.final_cl, 0);
        check("chg2_dones", r.dones, 1);

        vend_run(15, 1, r);
        check("chg15_finished", r.finished, 1);
        check("chg15_pulses", r.pulses, 15);
        check("chg15_on_cycles", r.on_cyc, 30);
        check("chg15_cl_rise1", r.cl_rise1, 15);
        check("chg15_final_cl", r.final_cl, 0);
        check("chg15_busy_after", r.busy_after, 0);

        // Reset asserted during the second PAY_ON of a 5-coin payout.
        bus.vend_req  = 1'b1;
        bus.change_in = 4'd5;
        rises  = 0;
        prev_h = 1'b0;
        for (int i = 0; i < 200 && rises < 2; i++) begin
            step();
            bus.vend_req  = 1'b0;
            bus.collected = (bus.state == 3'd2);
            if (bus.hopper_pulse && !prev_h) rises++;
            prev_h = bus.hopper_pulse;
        end
        bus.collected = 1'b0;
        check("rst_reached_pay2", rises, 2);
        check("rst_pre_state", int'(bus.state), 3);
        #3;
        rst = 1'b0;
        #1;
        check("rst_mid_outputs", int'(outvec()), 0);
        step();
        @(negedge clk);
        rst = 1'b1;
        step();
        check("rst_release_idle", int'(outvec()), 0);
        vend_run(1, 2, r);
        check("post_rst_finished", r.finished, 1);
        check("post_rst_acks", r.acks, 1);
        check("post_rst_pulses", r.pulses, 1);
        check("post_rst_final_cl", r.final_cl, 0);

`ifdef VEND_COLLECT_TIMEOUT_EN
        vend_run(1, -1, r);
        check("tmo_finished", r.finished, 1);
        check("tmo_wait_cycles", r.wait_cyc, 64);
        check("tmo_pulses", r.pulses, 1);
        check("tmo_flag_at_done", r.tmo_at_done, 1);
        check("tmo_sticky_idle", int'(bus.timeout), 1);
        vend_run(0, 0, r);
        check("tmo_clear_at_ack", r.tmo_at_ack, 0);
        check("tmo_clear_done", r.tmo_at_done, 0);
`else
        bus.vend_req  = 1'b1;
        bus.change_in = 4'd0;
        step();
        bus.vend_req = 1'b0;
        repeat (100) step();
        check("nowait_state", int'(bus.state), 2);
        check("nowait_timeout", int'(bus.timeout), 0);
        bus.collected = 1'b1;
        step();
        bus.collected = 1'b0;
        check("nowait_done", int'(bus.done), 1);
        step();
        check("nowait_idle", int'(bus.busy), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
